frame_config_ctrl: RTL
======================

Name: frame_config_ctrl

Overview:
- Configuration-port controller that sits directly upstream of the fabric's terminal and edge tiles.
- Consumes a 32-bit bitstream word stream and builds the per-row FrameData vectors, one word per tile row.
- Once all rows of a frame are loaded, it issues a single-cycle one-hot FrameStrobe on the addressed column/frame line.
- Tiles then latch the frame and forward FrameData/FrameStrobe through their buffer chains.

Parameters:
- FrameBitsPerRow, 32, width of one row's frame word.
- MaxFramesPerCol, 20, frame-select lines per column.
- NumRows, 4, tile rows fed, equal to data words per frame.
- NumColumns, 4, tile columns fed.
- SyncWord, 32'hFAB0_FAB1, start-of-configuration marker.
- DesyncWord, 32'hFAB0_FAB0, end-of-configuration marker.

Ports:
- UserCLK  input  1  clock.
- Reset  input  1  asynchronous active-high reset.
- WordData  input  32  bitstream word.
- WordValid  input  1  WordData valid.
- WordReady  output  1  controller accepts word this cycle.
- FrameData  output  NumRows*FrameBitsPerRow  row r at bits [r*FrameBitsPerRow +: FrameBitsPerRow].
- FrameStrobe  output  NumColumns*MaxFramesPerCol  column c at bits [c*MaxFramesPerCol +: MaxFramesPerCol].
- ConfigBusy  output  1  high from sync accepted until desync accepted.
- AddrError  output  1  sticky out-of-range address flag.

Behaviour:
- Clock and reset: one clock, UserCLK. Reset is asynchronous and active-high. While Reset is asserted, all outputs are 0 and the state machine is in IDLE.
- Word transfer: a word transfers when WordValid && WordReady. WordReady = 1 in IDLE, HEADER and DATA; 0 in STROBE.
- Address word format: [31:24] column index; [23:19] frame index; [18:0] ignored.
- IDLE:
  - Transferred word == SyncWord: go to HEADER and set ConfigBusy.
  - Any other word: discarded.
- HEADER:
  - DesyncWord: go to IDLE and clear ConfigBusy.
  - SyncWord: ignored; stay in HEADER.
  - Any other word is an address word: latch column and frame index, clear row counter, go to DATA.
- DATA:
  - Each transferred word is written into FrameData row (NumRows-1-rowcnt), so the first word lands in the top row. rowcnt then increments.
  - The write to the last row moves the state to STROBE.
  - No marker decoding in DATA: sync/desync values are treated as data.
- STROBE, exactly one cycle:
  - If column < NumColumns and frame < MaxFramesPerCol: FrameStrobe bit [column*MaxFramesPerCol + frame] = 1; all other bits 0.
  - Otherwise: FrameStrobe stays all-zero and AddrError is set.
  - Next state is HEADER.
- FrameStrobe is registered. It is high only during the STROBE cycle and is 0 in every other cycle.
- FrameData is registered. It holds its value until overwritten and is never cleared except by Reset. FrameData is stable for the whole STROBE cycle.
- Latency: the strobe is asserted in the cycle after the final data word transfers. The minimum frame period is NumRows+2 cycles (header + NumRows data + strobe).
- WordValid gaps are allowed in any state. State and counters hold while WordValid = 0.
- AddrError: sticky; cleared only by Reset. It does not block later frames.
- Reset mid-frame: partial data is discarded, no strobe is issued, and the controller returns to IDLE requiring a fresh SyncWord.
- Width rules: rowcnt uses $clog2(NumRows) bits and wraps only through the transition to STROBE. Column and frame comparisons are unsigned.

Decomposition:
- Shared package frame_cfg_pkg holds:
  - state enum {IDLE, HEADER, DATA, STROBE};
  - SyncWord and DesyncWord constants;
  - address field bit positions.
- One natural sub-module: frame_strobe_decode, which maps (column, frame, valid_range, enable) to the one-hot FrameStrobe vector. It is combinational; its output is registered in the parent.

Test Plan:
- Reset with WordValid=1 and random data -> all outputs 0; no strobe until SyncWord is sent.
- Sync; address 32'h0118_0000 (column 1, frame 3); data 11111111, 22222222, 33333333, 44444444 -> FrameData row3=11111111 … row0=44444444; FrameStrobe bit 23 high for exactly one cycle, the cycle after the 4th word.
- Address with column 5 (≥ NumColumns) plus 4 data words -> FrameStrobe stays 0; AddrError=1 and remains set; a following valid frame still strobes correctly.
- WordValid toggling 1-0-1 during DATA, plus a data word equal to DesyncWord -> accepted as data; strobe still issued; WordReady=0 during the STROBE cycle only.
- Reset asserted after 2 data words -> no strobe; next frame sent without a sync word is ignored; after resync the frame loads normally.
- DesyncWord in HEADER -> ConfigBusy falls the next cycle; subsequent address words are ignored until the next SyncWord.

Source files
------------

// File: rtl/frame_cfg_pkg.sv
// Shared types and constants for the frame configuration controller.
package frame_cfg_pkg;

    localparam int unsigned FRAME_BITS_PER_ROW = 32;
    localparam int unsigned MAX_FRAMES_PER_COL = 20;
    localparam int unsigned NUM_ROWS           = 4;
    localparam int unsigned NUM_COLUMNS        = 4;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned DATA_W    = NUM_ROWS * FRAME_BITS_PER_ROW;
    localparam int unsigned STROBE_W  = NUM_COLUMNS * MAX_FRAMES_PER_COL;
    localparam int unsigned ROW_CNT_W = $clog2(NUM_ROWS);

    // Address word layout: [31:24] column, [23:19] frame, rest ignored
    localparam int unsigned COL_LSB = 24;
    localparam int unsigned COL_W   = 8;
    localparam int unsigned FRM_LSB = 19;
    localparam int unsigned FRM_W   = 5;

    localparam logic [WORD_W-1:0] SYNC_WORD   = 32'hFAB0_FAB1;
    localparam logic [WORD_W-1:0] DESYNC_WORD = 32'hFAB0_FAB0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2,
        STROBE = 2'd3
    } cfg_state_e;

    function automatic logic addr_in_range(input logic [COL_W-1:0] col,
                                           input logic [FRM_W-1:0] frm);
        return (32'(col) < NUM_COLUMNS) && (32'(frm) < MAX_FRAMES_PER_COL);
    endfunction

endpackage

// File: rtl/frame_config_ctrl_strobe_decode.sv
// Maps a latched column/frame address to the one-hot FrameStrobe vector.
module frame_strobe_decode
    import frame_cfg_pkg::*;
(
    input  logic [COL_W-1:0]    col_i,
    input  logic [FRM_W-1:0]    frm_i,
    input  logic                valid_range_i,
    input  logic                enable_i,
    output logic [STROBE_W-1:0] strobe_c_o
);

    always_comb begin
        strobe_c_o = '0;
        for (int unsigned c = 0; c < NUM_COLUMNS; c++) begin
            for (int unsigned f = 0; f < MAX_FRAMES_PER_COL; f++) begin
                if (enable_i && valid_range_i &&
                    (col_i == COL_W'(c)) && (frm_i == FRM_W'(f))) begin
                    strobe_c_o[c * MAX_FRAMES_PER_COL + f] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/frame_config_ctrl.sv
// Bitstream word consumer: loads per-row FrameData and fires one FrameStrobe per frame.
module frame_config_ctrl
    import frame_cfg_pkg::*;
(
    input  logic                UserCLK,
    input  logic                Reset,
    input  logic [WORD_W-1:0]   WordData,
    input  logic                WordValid,
    output logic                WordReady,
    output logic [DATA_W-1:0]   FrameData,
    output logic [STROBE_W-1:0] FrameStrobe,
    output logic                ConfigBusy,
    output logic                AddrError
);

    cfg_state_e           state_q;
    logic [COL_W-1:0]     col_q;
    logic [FRM_W-1:0]     frm_q;
    logic [ROW_CNT_W-1:0] rowcnt_q;
    logic [DATA_W-1:0]    frame_data_q;
    logic [STROBE_W-1:0]  strobe_q;
    logic                 busy_q;
    logic                 addr_err_q;
    logic                 ready_q;

    logic                 word_xfer_c;
    logic                 last_row_c;
    logic                 in_range_c;
    logic                 strobe_en_c;
    logic [ROW_CNT_W-1:0] row_sel_c;
    logic [STROBE_W-1:0]  strobe_d;

    assign word_xfer_c = WordValid && ready_q;
    assign last_row_c  = (rowcnt_q == ROW_CNT_W'(NUM_ROWS - 1));
    assign in_range_c  = addr_in_range(col_q, frm_q);
    assign strobe_en_c = (state_q == DATA) && word_xfer_c && last_row_c;
    // First data word lands in the top row
    assign row_sel_c   = ROW_CNT_W'(NUM_ROWS - 1) - rowcnt_q;

    frame_strobe_decode u_strobe_decode (
        .col_i         (col_q),
        .frm_i         (frm_q),
        .valid_range_i (in_range_c),
        .enable_i      (strobe_en_c),
        .strobe_c_o    (strobe_d)
    );

    // Strobe is computed on the final data word so it is visible during STROBE
    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            col_q        <= '0;
            frm_q        <= '0;
            rowcnt_q     <= '0;
            frame_data_q <= '0;
            strobe_q     <= '0;
            busy_q       <= 1'b0;
            addr_err_q   <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            strobe_q <= '0;
            ready_q  <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (word_xfer_c && (WordData == SYNC_WORD)) begin
                        state_q <= HEADER;
                        busy_q  <= 1'b1;
                    end
                end
                HEADER: begin
                    if (word_xfer_c) begin
                        if (WordData == DESYNC_WORD) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else if (WordData != SYNC_WORD) begin
                            col_q    <= WordData[COL_LSB +: COL_W];
                            frm_q    <= WordData[FRM_LSB +: FRM_W];
                            rowcnt_q <= '0;
                            state_q  <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (word_xfer_c) begin
                        frame_data_q[32'(row_sel_c) * FRAME_BITS_PER_ROW +: FRAME_BITS_PER_ROW] <= WordData;
                        rowcnt_q <= rowcnt_q + ROW_CNT_W'(1);
                        if (last_row_c) begin
                            state_q  <= STROBE;
                            ready_q  <= 1'b0;
                            strobe_q <= strobe_d;
                            if (!in_range_c) begin
                                addr_err_q <= 1'b1;
                            end
                        end
                    end
                end
                STROBE: begin
                    state_q <= HEADER;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign WordReady   = ready_q;
    assign FrameData   = frame_data_q;
    assign FrameStrobe = strobe_q;
    assign ConfigBusy  = busy_q;
    assign AddrError   = addr_err_q;

endmodule
